llc_trace_req_queue: RTL and testbench
======================================

LLC_TRACE_REQ_QUEUE -- requirements
Module: llc_trace_req_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: FIFO entries, power of two, 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: a trace command is offered.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-006 The block SHALL have port cmd_op, input, 4 bits: trace opcode 0-9.
REQ-007 The block SHALL have port cmd_addr, input, 32 bits: byte address.
REQ-008 The block SHALL have port req_valid, output, 1 bit: a decoded request is presented to the cache controller.
REQ-009 The block SHALL have port req_ready, input, 1 bit: the cache controller consumes the request.
REQ-010 The block SHALL have port req_op, output, 4 bits: the original opcode.
REQ-011 The block SHALL have port req_kind, output, 2 bits: 0 CPU_RD (op 0, 2), 1 CPU_WR (op 1), 2 SNOOP (op 3-6), 3 MAINT (op 8, 9).
REQ-012 The block SHALL have port req_tag, output, 12 bits: address[31:20].
REQ-013 The block SHALL have port req_index, output, 14 bits: address[19:6].
REQ-014 The block SHALL have port req_offset, output, 6 bits: address[5:0].
REQ-015 The block SHALL have port bad_op, output, 1 bit: a one-cycle pulse when an illegal opcode is dropped.
REQ-016 The block SHALL have port occupancy, output, 5 bits: the current entry count.

Function
REQ-017 The block SHALL perform a handshake transfer on each side only on a cycle where valid and ready are both 1.
REQ-018 The block SHALL drive cmd_ready = (occupancy != DEPTH), with no combinational path from req_ready.
REQ-019 The block SHALL enqueue an accepted legal command (op 0-6, 8, 9) at the write pointer; the write pointer wraps from DEPTH-1 to 0.
REQ-020 The block SHALL consume but not enqueue an accepted illegal command (op 7, 10-15), and SHALL assert bad_op for exactly the following cycle.
REQ-021 The block SHALL present an entry on req_valid/req_* no earlier than the cycle after it is enqueued; minimum latency is 1 cycle, with no same-cycle bypass.
REQ-022 The block SHALL hold req_* stable while req_valid=1 and req_ready=0.
REQ-023 The block SHALL produce req_tag, req_index, req_offset and req_kind by combinational decode of the head entry; the FIFO stores only op and addr.
REQ-024 On a pop, the block SHALL advance the read pointer with wrap and present the next entry in the same cycle if one exists, otherwise drop req_valid.
REQ-025 On a simultaneous push and pop, the block SHALL leave occupancy unchanged and keep both pointers advancing; this is legal at any non-full occupancy.
REQ-026 When full, the block SHALL accept no push, even if a pop occurs that cycle.
REQ-027 When empty, the block SHALL hold req_valid at 0, ignore req_ready, and leave the read pointer unchanged.
REQ-028 The block SHALL preserve ordering strictly FIFO; it SHALL NOT reorder or merge snoops with CPU requests.
REQ-029 The block SHALL pass op 8 (clear) and op 9 (print) through in order as MAINT, with no local side effect.

Reset
REQ-030 While rst=1, the block SHALL hold occupancy at 0, both pointers at 0, req_valid at 0, bad_op at 0, cmd_ready at 0, and req_* at 0.
REQ-031 The block SHALL have cmd_ready=1 in the first cycle after rst deasserts; no handshake SHALL occur during rst.
REQ-032 A reset asserted mid-operation SHALL discard all queued entries and any pending bad_op pulse at the next edge.

Configuration
REQ-033 When macro LLC_TRACE_STATS_EN is defined, the block SHALL add 32-bit outputs stat_rd, stat_wr, stat_snoop and stat_bad.
REQ-034 With LLC_TRACE_STATS_EN defined, the block SHALL increment the matching counter on each accepted command by kind (stat_bad for illegal opcodes), saturate at 0xFFFFFFFF, and clear the counters on rst.
REQ-035 Without LLC_TRACE_STATS_EN, the block SHALL have neither the stat ports nor the counters; all other behaviour is identical.

Verification
REQ-036 The bench SHALL check: reset, then push op 0 at addr 0x12345678 with req_ready=1 -> next cycle req_valid=1, req_kind=0, req_tag=0x123, req_index=0x1159, req_offset=0x38.
REQ-037 The bench SHALL check: with DEPTH=4 and req_ready=0, push 5 commands -> cmd_ready=0 after the 4th, the 5th is stalled, occupancy=4.
REQ-038 The bench SHALL check: full FIFO, then req_ready=1 and cmd_valid=1 for 1 cycle -> pop occurs, no push, occupancy=3.
REQ-039 The bench SHALL check: push op 7 -> bad_op=1 for one cycle, occupancy unchanged, stat_bad=1 when LLC_TRACE_STATS_EN is defined.
REQ-040 The bench SHALL check: 10 push+pop cycles at occupancy 2 -> order preserved across pointer wrap, occupancy stays 2.
REQ-041 The bench SHALL check: rst asserted with 3 entries queued -> next cycle req_valid=0, occupancy=0, and cmd_ready=1 after release.

Source files
------------

// File: rtl/llc_trace_req_queue.sv
// Trace command queue: drops illegal opcodes, stores op/addr in a FIFO, decodes the head for the LLC.
// Optional per-kind command counters are enabled with `define LLC_TRACE_STATS_EN.
module llc_trace_req_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [3:0]  req_op,
    output logic [1:0]  req_kind,
    output logic [11:0] req_tag,
    output logic [13:0] req_index,
    output logic [5:0]  req_offset,
    output logic        bad_op,
`ifdef LLC_TRACE_STATS_EN
    output logic [31:0] stat_rd,
    output logic [31:0] stat_wr,
    output logic [31:0] stat_snoop,
    output logic [31:0] stat_bad,
`endif
    output logic [4:0]  occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [4:0] FULL = 5'(DEPTH);

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] addr;
    } entry_t;

    typedef enum logic [1:0] {CPU_RD = 2'd0, CPU_WR = 2'd1, SNOOP = 2'd2, MAINT = 2'd3} kind_e;

    function automatic kind_e kind_of(input logic [3:0] op);
        case (op)
            4'd1:                      kind_of = CPU_WR;
            4'd3, 4'd4, 4'd5, 4'd6:    kind_of = SNOOP;
            4'd8, 4'd9:                kind_of = MAINT;
            default:                   kind_of = CPU_RD;
        endcase
    endfunction

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [4:0]      count;
    logic            legal, accept, push, pop;

    assign legal     = (cmd_op <= 4'd6) || (cmd_op == 4'd8) || (cmd_op == 4'd9);
    assign cmd_ready = !rst && (count != FULL);
    assign accept    = cmd_valid && cmd_ready;
    assign push      = accept && legal;
    assign req_valid = !rst && (count != 5'd0);
    assign pop       = req_valid && req_ready;
    assign occupancy = count;

    // Outputs are forced to zero when nothing is presented so req_* read 0 in reset/empty.
    assign head       = req_valid ? mem[rd_ptr] : '0;
    assign req_op     = head.op;
    assign req_kind   = req_valid ? 2'(kind_of(head.op)) : 2'd0;
    assign req_tag    = head.addr[31:20];
    assign req_index  = head.addr[19:6];
    assign req_offset = head.addr[5:0];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{op: cmd_op, addr: cmd_addr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            bad_op <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            bad_op <= accept && !legal;
        end
    end

`ifdef LLC_TRACE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd    <= '0;
            stat_wr    <= '0;
            stat_snoop <= '0;
            stat_bad   <= '0;
        end else if (accept) begin
            if (!legal) begin
                if (stat_bad != '1) stat_bad <= stat_bad + 32'd1;
            end else begin
                // Maintenance ops have no counter of their own.
                case (kind_of(cmd_op))
                    CPU_RD:  if (stat_rd != '1)    stat_rd    <= stat_rd + 32'd1;
                    CPU_WR:  if (stat_wr != '1)    stat_wr    <= stat_wr + 32'd1;
                    SNOOP:   if (stat_snoop != '1) stat_snoop <= stat_snoop + 32'd1;
                    default: ;
                endcase
            end
        end
    end
`endif
endmodule

// File: tb/tb_llc_trace_req_queue.sv
// Directed bench for llc_trace_req_queue (DEPTH=4): decode, full/stall, bad op, wrap ordering, reset.
module tb_llc_trace_req_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [1:0]  req_kind;
    logic [11:0] req_tag;
    logic [13:0] req_index;
    logic [5:0]  req_offset;
    logic        bad_op;
    logic [4:0]  occupancy;
`ifdef LLC_TRACE_STATS_EN
    logic [31:0] stat_rd, stat_wr, stat_snoop, stat_bad;
`endif

    int n_chk = 0;
    int n_fail = 0;

    // Legal opcodes and their expected kinds, computed by hand.
    logic [3:0] legal_ops [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    logic [1:0] legal_knd [9] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};

    llc_trace_req_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_kind(req_kind),
        .req_tag(req_tag), .req_index(req_index), .req_offset(req_offset),
        .bad_op(bad_op),
`ifdef LLC_TRACE_STATS_EN
        .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_snoop(stat_snoop), .stat_bad(stat_bad),
`endif
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 4'd0; cmd_addr = 32'hFFFF_FFFF; req_ready = 1'b1;
        tick; tick;
        n_chk++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
        n_chk++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got %b exp 0", req_valid); end
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
        n_chk++; if (bad_op !== 1'b0) begin n_fail++; $display("FAIL rst_bad_op got %b exp 0", bad_op); end
        n_chk++; if ({req_op, req_tag, req_index, req_offset} !== 36'd0) begin n_fail++; $display("FAIL rst_req_fields got %h exp 0", {req_op, req_tag, req_index, req_offset}); end
        rst = 1'b0; cmd_valid = 1'b0;
        #1;
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %b exp 1", cmd_ready); end
    endtask

    task automatic test_decode;
        req_ready = 1'b1; cmd_valid = 1'b1; cmd_op = 4'd0; cmd_addr = 32'h1234_5678;
        #1;
        n_chk++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL dec_no_bypass got %b exp 0", req_valid); end
        tick;
        cmd_valid = 1'b0;
        #1;
        n_chk++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL dec_valid got %b exp 1", req_valid); end
        n_chk++; if (req_kind !== 2'd0) begin n_fail++; $display("FAIL dec_kind got %0d exp 0", req_kind); end
        n_chk++; if (req_tag !== 12'h123) begin n_fail++; $display("FAIL dec_tag got %h exp 123", req_tag); end
        n_chk++; if (req_index !== 14'h1159) begin n_fail++; $display("FAIL dec_index got %h exp 1159", req_index); end
        n_chk++; if (req_offset !== 6'h38) begin n_fail++; $display("FAIL dec_offset got %h exp 38", req_offset); end
        tick;
        n_chk++; if (req_valid !== 1'b0 || occupancy !== 5'd0) begin n_fail++; $display("FAIL dec_drain got v=%b occ=%0d exp v=0 occ=0", req_valid, occupancy); end
        req_ready = 1'b0;
    endtask

    task automatic test_full;
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_op = 4'(i + 1); cmd_addr = 32'(i + 1) << 6;
            #1;
            n_chk++; if (cmd_ready !== (i < 4)) begin n_fail++; $display("FAIL full_ready[%0d] got %b exp %b", i, cmd_ready, (i < 4)); end
            tick;
        end
        n_chk++; if (occupancy !== 5'd4) begin n_fail++; $display("FAIL full_occ got %0d exp 4", occupancy); end
        n_chk++; if (req_op !== 4'd1 || req_kind !== 2'd1) begin n_fail++; $display("FAIL full_head got op=%0d kind=%0d exp op=1 kind=1", req_op, req_kind); end
    endtask

    task automatic test_full_pop;
        // 5th command (op 5) still offered while the head is popped.
        req_ready = 1'b1;
        #1;
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fpop_ready got %b exp 0", cmd_ready); end
        tick;
        req_ready = 1'b0; cmd_valid = 1'b0;
        #1;
        n_chk++; if (occupancy !== 5'd3) begin n_fail++; $display("FAIL fpop_occ got %0d exp 3", occupancy); end
        for (int i = 0; i < 3; i++) begin
            req_ready = 1'b1;
            #1;
            n_chk++; if (req_op !== 4'(i + 2) || req_index !== 14'(i + 2) || req_kind !== ((i == 0) ? 2'd0 : 2'd2)) begin
                n_fail++; $display("FAIL fpop_order[%0d] got op=%0d idx=%0d kind=%0d exp op=%0d", i, req_op, req_index, req_kind, i + 2);
            end
            tick;
        end
        req_ready = 1'b0;
        n_chk++; if (occupancy !== 5'd0 || req_valid !== 1'b0) begin n_fail++; $display("FAIL fpop_empty got occ=%0d v=%b exp 0 0", occupancy, req_valid); end
    endtask

    task automatic test_bad_op;
        cmd_valid = 1'b1; cmd_op = 4'd7; cmd_addr = 32'hDEAD_BEEF;
        tick;
        cmd_valid = 1'b0;
        #1;
        n_chk++; if (bad_op !== 1'b1) begin n_fail++; $display("FAIL bad_pulse got %b exp 1", bad_op); end
        n_chk++; if (occupancy !== 5'd0 || req_valid !== 1'b0) begin n_fail++; $display("FAIL bad_occ got occ=%0d v=%b exp 0 0", occupancy, req_valid); end
`ifdef LLC_TRACE_STATS_EN
        n_chk++; if (stat_bad !== 32'd1) begin n_fail++; $display("FAIL stat_bad got %0d exp 1", stat_bad); end
        n_chk++; if (stat_rd !== 32'd2 || stat_wr !== 32'd1 || stat_snoop !== 32'd2) begin n_fail++; $display("FAIL stat_kinds got rd=%0d wr=%0d sn=%0d exp 2 1 2", stat_rd, stat_wr, stat_snoop); end
`endif
        tick;
        n_chk++; if (bad_op !== 1'b0) begin n_fail++; $display("FAIL bad_one_cycle got %b exp 0", bad_op); end
    endtask

    task automatic test_back_to_back;
        req_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            cmd_valid = 1'b1; cmd_op = legal_ops[j]; cmd_addr = 32'(j) << 6;
            tick;
        end
        for (int k = 0; k < 10; k++) begin
            cmd_valid = 1'b1; cmd_op = legal_ops[(k + 2) % 9]; cmd_addr = 32'(k + 2) << 6;
            req_ready = 1'b1;
            #1;
            n_chk++; if (req_valid !== 1'b1 || req_index !== 14'(k) || req_op !== legal_ops[k % 9] || req_kind !== legal_knd[k % 9] || occupancy !== 5'd2) begin
                n_fail++; $display("FAIL b2b[%0d] got v=%b idx=%0d op=%0d kind=%0d occ=%0d exp idx=%0d op=%0d kind=%0d occ=2",
                                   k, req_valid, req_index, req_op, req_kind, occupancy, k, legal_ops[k % 9], legal_knd[k % 9]);
            end
            tick;
        end
        cmd_valid = 1'b0;
        for (int k = 10; k < 12; k++) begin
            #1;
            n_chk++; if (req_index !== 14'(k) || req_op !== legal_ops[k % 9]) begin n_fail++; $display("FAIL b2b_drain[%0d] got idx=%0d op=%0d", k, req_index, req_op); end
            tick;
        end
        req_ready = 1'b0;
        n_chk++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL b2b_empty got %0d exp 0", occupancy); end
    endtask

    task automatic test_reset_mid;
        req_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cmd_valid = 1'b1; cmd_op = 4'd3; cmd_addr = 32'(j) << 6;
            tick;
        end
        n_chk++; if (occupancy !== 5'd3) begin n_fail++; $display("FAIL mid_fill got %0d exp 3", occupancy); end
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 4'd7;
        #1;
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready got %b exp 0", cmd_ready); end
        tick;
        n_chk++; if (req_valid !== 1'b0 || occupancy !== 5'd0 || bad_op !== 1'b0) begin n_fail++; $display("FAIL mid_rst got v=%b occ=%0d bad=%b exp 0 0 0", req_valid, occupancy, bad_op); end
`ifdef LLC_TRACE_STATS_EN
        n_chk++; if ({stat_rd, stat_wr, stat_snoop, stat_bad} !== 128'd0) begin n_fail++; $display("FAIL mid_stats got rd=%0d wr=%0d sn=%0d bad=%0d exp 0", stat_rd, stat_wr, stat_snoop, stat_bad); end
`endif
        rst = 1'b0; cmd_valid = 1'b0;
        #1;
        n_chk++; if (cmd_ready !== 1'b1 || occupancy !== 5'd0) begin n_fail++; $display("FAIL mid_release got rdy=%b occ=%0d exp 1 0", cmd_ready, occupancy); end
        tick;
        n_chk++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stay_empty got %b exp 0", req_valid); end
    endtask

    initial begin
        test_reset;
        test_decode;
        test_full;
        test_full_pop;
        test_bad_op;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
